display_sev_segm_ctrl: RTL and testbench

DISPLAY_SEV_SEGM_CTRL -- requirements
Module: display_sev_segm_ctrl

---
 rtl/display_pkg.sv | 16 +
 rtl/binaryToHexSevSegm.sv | 31 +++
 rtl/display_sev_segm_ctrl.sv | 160 ++++++++++++++++
 tb/tb_display_sev_segm_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
// Pure definitions: no latency, no flow control.
package display_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Segment patterns are active-low, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/binaryToHexSevSegm.sv
// Nibble to active-low hex glyph decoder (segments a..g on bits 0..6).
// Combinational, zero latency, no flow control.
module binaryToHexSevSegm (
  input  logic [3:0] i_bin,
  output logic [6:0] o_segm
);

  always_comb begin
    o_segm = 7'b1111111;
    case (i_bin)
      4'h0: o_segm = 7'b1000000;
      4'h1: o_segm = 7'b1111001;
      4'h2: o_segm = 7'b0100100;
      4'h3: o_segm = 7'b0110000;
      4'h4: o_segm = 7'b0011001;
      4'h5: o_segm = 7'b0010010;
      4'h6: o_segm = 7'b0000010;
      4'h7: o_segm = 7'b1111000;
      4'h8: o_segm = 7'b0000000;
      4'h9: o_segm = 7'b0010000;
      4'hA: o_segm = 7'b0001000;
      4'hB: o_segm = 7'b0000011;
      4'hC: o_segm = 7'b1000110;
      4'hD: o_segm = 7'b0100001;
      4'hE: o_segm = 7'b0000110;
      4'hF: o_segm = 7'b0001110;
      default: o_segm = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_sev_segm_ctrl.sv
// Multi-digit seven-segment controller: hex loads show after 1 cycle, decimal loads after 4*DIGITS
// cycles of double-dabble; in_ready drops for the whole conversion and requests meanwhile are dropped.
module display_sev_segm_ctrl
  import display_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic                  in_decimal,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7*DIGITS-1:0]   disp,
  output logic                  overflow
);

  localparam int NB = 4 * DIGITS;
  localparam int CW = $clog2(NB);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] LAST_BIT  = CW'(NB - 1);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("DIGITS out of range");
  end

  state_t          r_state;
  logic            r_in_ready;
  logic [NB-1:0]   r_digits;
  logic [NB-1:0]   r_shift;
  logic [NB-1:0]   r_bcd;
  logic [CW-1:0]   r_bit_cnt;
  logic            r_ovf_acc;
  logic            r_overflow;
  logic            r_loaded;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_ph;

  logic [NB-1:0]         w_bcd_adj;
  logic [NB-1:0]         w_bcd_next;
  logic                  w_carry;
  logic [7*DIGITS-1:0]   w_glyph;
  logic [DIGITS-1:0]     w_lz;
  logic                  w_upper_zero;

  // Add-3 on every nibble >= 5, then shift one input bit in from the top of r_shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_next = {w_bcd_adj[NB-2:0], r_shift[NB-1]};
  assign w_carry    = w_bcd_adj[NB-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_digits   <= '0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_ovf_acc  <= 1'b0;
      r_overflow <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (in_decimal) begin
              r_shift    <= in_value;
              r_bcd      <= '0;
              r_bit_cnt  <= '0;
              r_ovf_acc  <= 1'b0;
              r_state    <= ST_CONV;
              r_in_ready <= 1'b0;
            end else begin
              r_digits   <= in_value;
              r_overflow <= 1'b0;
              r_loaded   <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          r_shift   <= {r_shift[NB-2:0], 1'b0};
          r_bcd     <= w_bcd_next;
          r_ovf_acc <= r_ovf_acc | w_carry;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_digits   <= w_bcd_next;
            r_overflow <= r_ovf_acc | w_carry;
            r_loaded   <= 1'b1;
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (r_blink_cnt == BLINK_TOP) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= ~r_blink_ph;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    binaryToHexSevSegm u_dec (
      .i_bin  (r_digits[4*g +: 4]),
      .o_segm (w_glyph[7*g +: 7])
    );
  end

  // w_lz[i] marks a digit with only zeros at and above it; digit 0 never qualifies.
  always_comb begin
    w_lz         = '0;
    w_upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_upper_zero = w_upper_zero & (r_digits[4*i +: 4] == 4'd0);
      w_lz[i]      = w_upper_zero;
    end
  end

  always_comb begin
    disp = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_loaded || (r_blink_ph && blink_mask[i])) begin
        disp[7*i +: 7] = SEG_BLANK;
      end else if (r_overflow) begin
        disp[7*i +: 7] = SEG_DASH;
      end else if (blank_lz && w_lz[i]) begin
        disp[7*i +: 7] = SEG_BLANK;
      end else begin
        disp[7*i +: 7] = w_glyph[7*i +: 7];
      end
    end
  end

  assign in_ready = r_in_ready;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_display_sev_segm_ctrl.sv
// Bench for display_sev_segm_ctrl: vector table, hand sequences for blink/ignore/reset-abort,
// and random loads compared against a digit-level reference model.
module tb_display_sev_segm_ctrl;

  localparam int DIGITS = 8;
  localparam int BLINK  = 4;
  localparam logic [55:0] ALL_OFF = '1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_decimal;
  logic        blank_lz;
  logic [7:0]  blink_mask;
  logic [55:0] disp;
  logic        overflow;

  always #5 clk = ~clk;

  display_sev_segm_ctrl #(.DIGITS(DIGITS), .BLINK_DIV(BLINK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_decimal (in_decimal),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .disp       (disp),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph [16];

  // Reference model: what the display should show, tracked as decimal/hex digit values.
  bit          m_loaded = 1'b0;
  bit          m_ovf    = 1'b0;
  int          m_nib [8];
  int unsigned edge_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  typedef struct packed {
    logic [31:0] value;
    logic        dec;
    logic        blz;
    logic [63:0] exp_str;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] model_disp();
    logic [55:0] d;
    int msd;
    bit ph;
    d   = '1;
    msd = 0;
    ph  = ((edge_cnt / BLINK) % 2) == 1;
    for (int i = 0; i < DIGITS; i++) if (m_nib[i] != 0) msd = i;
    for (int i = 0; i < DIGITS; i++) begin
      if (!m_loaded || (ph && blink_mask[i])) d[7*i +: 7] = 7'b1111111;
      else if (m_ovf)                         d[7*i +: 7] = 7'b0111111;
      else if (blank_lz && i > msd)           d[7*i +: 7] = 7'b1111111;
      else                                    d[7*i +: 7] = glyph[m_nib[i]];
    end
    return d;
  endfunction

  function automatic logic [55:0] str_disp(input logic [63:0] s);
    logic [55:0] d;
    logic [7:0]  c;
    d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      c = s[8*i +: 8];
      if (c >= "0" && c <= "9")      d[7*i +: 7] = glyph[int'(c) - 48];
      else if (c >= "A" && c <= "F") d[7*i +: 7] = glyph[int'(c) - 55];
      else if (c == "-")             d[7*i +: 7] = 7'b0111111;
      else                           d[7*i +: 7] = 7'b1111111;
    end
    return d;
  endfunction

  task automatic model_hex(input logic [31:0] v);
    for (int i = 0; i < DIGITS; i++) m_nib[i] = int'((v >> (4*i)) & 32'hF);
    m_ovf    = 1'b0;
    m_loaded = 1'b1;
  endtask

  task automatic model_dec(input logic [31:0] v);
    longint unsigned lv;
    longint unsigned p;
    lv = longint'(v);
    p  = 1;
    if (lv > 64'd99999999) begin
      m_ovf = 1'b1;
    end else begin
      m_ovf = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        m_nib[i] = int'((lv / p) % 10);
        p = p * 10;
      end
    end
    m_loaded = 1'b1;
  endtask

  task automatic check_disp(input string name);
    check(name, 64'(disp), 64'(model_disp()));
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic apply_load(input logic [31:0] v, input bit dec, input bit poke, input string tag);
    check({tag, " ready_before"}, 64'(in_ready), 64'd1);
    in_value   = v;
    in_decimal = dec;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_value   = $urandom;
    in_decimal = 1'($urandom);
    if (!dec) begin
      model_hex(v);
    end else begin
      for (int c = 0; c < 32; c++) begin
        check({tag, " ready_conv"}, 64'(in_ready), 64'd0);
        check_disp({tag, " hold_conv"});
        if (poke && c == 5) begin
          in_value   = 32'h0;
          in_decimal = 1'b0;
          in_valid   = 1'b1;
        end
        if (poke && c == 6) in_valid = 1'b0;
        @(negedge clk);
      end
      model_dec(v);
    end
    check({tag, " ready_after"}, 64'(in_ready), 64'd1);
    check({tag, " disp"}, 64'(disp), 64'(model_disp()));
    check({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  initial begin
    logic [6:0] prev_d0;
    int         toggles;

    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    for (int i = 0; i < DIGITS; i++) m_nib[i] = 0;

    tbl[0]  = '{32'h1234ABCD,    1'b0, 1'b0, "1234ABCD", 1'b0};
    tbl[1]  = '{32'd12345678,    1'b1, 1'b0, "12345678", 1'b0};
    tbl[2]  = '{32'd100000000,   1'b1, 1'b0, "--------", 1'b1};
    tbl[3]  = '{32'h00000000,    1'b0, 1'b0, "00000000", 1'b0};
    tbl[4]  = '{32'h000000F0,    1'b0, 1'b1, "      F0", 1'b0};
    tbl[5]  = '{32'h000000F0,    1'b0, 1'b0, "000000F0", 1'b0};
    tbl[6]  = '{32'd42,          1'b1, 1'b1, "      42", 1'b0};
    tbl[7]  = '{32'd99999999,    1'b1, 1'b0, "99999999", 1'b0};
    tbl[8]  = '{32'd0,           1'b1, 1'b1, "       0", 1'b0};
    tbl[9]  = '{32'hFFFFFFFF,    1'b0, 1'b1, "FFFFFFFF", 1'b0};
    tbl[10] = '{32'd4294967295,  1'b1, 1'b1, "--------", 1'b1};
    tbl[11] = '{32'h00A00000,    1'b0, 1'b1, "  A00000", 1'b0};

    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_value   = '0;
    in_decimal = 1'b0;
    blank_lz   = 1'b1;
    blink_mask = 8'hFF;
    #1 rst_n = 1'b0;
    #1;
    check("reset disp", 64'(disp), 64'(ALL_OFF));
    check("reset ready", 64'(in_ready), 64'd1);
    check("reset overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      blank_lz   = 1'($urandom);
      blink_mask = 8'($urandom);
      #1 check("idle after reset disp", 64'(disp), 64'(ALL_OFF));
      @(negedge clk);
    end

    blink_mask = 8'h00;
    for (int k = 0; k < 12; k++) begin
      blank_lz = tbl[k].blz;
      apply_load(tbl[k].value, tbl[k].dec, 1'b0, $sformatf("vec%0d", k));
      check($sformatf("vec%0d glyphs", k), 64'(disp), 64'(str_disp(tbl[k].exp_str)));
      check($sformatf("vec%0d ovf", k), 64'(overflow), 64'(tbl[k].exp_ovf));
    end

    // Blink: digit 0 must toggle exactly every BLINK cycles, the rest stay put.
    blank_lz   = 1'b0;
    blink_mask = 8'h01;
    apply_load(32'h12345678, 1'b0, 1'b0, "blink");
    prev_d0 = disp[6:0];
    toggles = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("blink upper", 64'(disp[55:7]), 64'(str_disp("12345678") >> 7));
      check_disp("blink digit0");
      if (disp[6:0] != prev_d0) toggles++;
      prev_d0 = disp[6:0];
    end
    check("blink toggles", 64'(toggles), 64'd4);

    // A request during conversion is dropped, not queued.
    blink_mask = 8'h00;
    apply_load(32'd87654321, 1'b1, 1'b1, "ignore");
    check("ignore glyphs", 64'(disp), 64'(str_disp("87654321")));
    repeat (3) begin
      @(negedge clk);
      check("ignore stays idle", 64'(in_ready), 64'd1);
    end

    for (int n = 0; n < 40; n++) begin
      logic [31:0] v;
      bit          d;
      v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 999)) : $urandom;
      d = 1'($urandom_range(0, 1));
      blank_lz   = 1'($urandom);
      blink_mask = 8'($urandom);
      apply_load(v, d, 1'b0, $sformatf("rnd%0d", n));
      repeat (2) begin
        blank_lz   = 1'($urandom);
        blink_mask = 8'($urandom);
        #1 check_disp($sformatf("rnd%0d live", n));
        @(negedge clk);
      end
    end

    // Reset in the middle of a conversion: nothing old or partial may show afterwards.
    blank_lz   = 1'b0;
    blink_mask = 8'h00;
    apply_load(32'h11111111, 1'b0, 1'b0, "pre_abort");
    in_value   = 32'd87654321;
    in_decimal = 1'b1;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("abort busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort disp", 64'(disp), 64'(ALL_OFF));
    check("abort ready", 64'(in_ready), 64'd1);
    check("abort overflow", 64'(overflow), 64'd0);
    m_loaded = 1'b0;
    m_ovf    = 1'b0;
    for (int i = 0; i < DIGITS; i++) m_nib[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      blank_lz   = 1'($urandom);
      blink_mask = 8'($urandom);
      #1 check("after abort disp", 64'(disp), 64'(ALL_OFF));
      check("after abort ready", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    blank_lz   = 1'b1;
    blink_mask = 8'h00;
    apply_load(32'h00000042, 1'b0, 1'b0, "post_abort");
    check("post_abort glyphs", 64'(disp), 64'(str_disp("      42")));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
